// File: rtl/wb_ram_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter for the shared SRAM slave.
// Round-robin, cyc-locked grants; outstanding-transfer throttling; watchdog
// that converts a silent slave into a bus error for the current owner.
module wb_ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_bus,
    input  logic                    rst_bus,
    input  logic [1:0]              m_cyc_i,
    input  logic [1:0]              m_stb_i,
    input  logic [1:0]              m_we_i,
    input  logic [2*ADDR_W-1:0]     m_adr_i,
    input  logic [2*DATA_W-1:0]     m_dat_i,
    input  logic [2*(DATA_W/8)-1:0] m_sel_i,
    output logic [DATA_W-1:0]       m_dat_o,
    output logic [1:0]              m_ack_o,
    output logic [1:0]              m_err_o,
    output logic [1:0]              m_rty_o,
    output logic [1:0]              m_stall_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_W-1:0]       s_adr_o,
    output logic [DATA_W-1:0]       s_dat_o,
    output logic [DATA_W/8-1:0]     s_sel_o,
    input  logic [DATA_W-1:0]       s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    input  logic                    s_stall_i,
    output logic [1:0]              grant_o
);

    localparam int SEL_W = DATA_W / 8;
    // Timer only has to count up to TIMEOUT-1 before the watchdog fires.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TO_M1);
    localparam logic [3:0]       MAX_OUT_C = 4'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_q;
    logic             last_q;
    logic [3:0]       out_q;
    logic [TMR_W-1:0] timer_q;
    logic [1:0]       wd_err_q;

    logic own, g, cyc_g, stb_g, full, accept, resp, wd_fire;

    // Steer the owner onto the slave and route responses back to it only.
    always_comb begin
        own     = (state_q != IDLE);
        g       = (state_q == OWN1);
        cyc_g   = own & m_cyc_i[g];
        stb_g   = m_stb_i[g];
        full    = (out_q == MAX_OUT_C);

        s_cyc_o = cyc_g;
        s_stb_o = cyc_g & stb_g & ~full;
        s_we_o  = own & m_we_i[g];
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (own) begin
            s_adr_o = g ? m_adr_i[ADDR_W +: ADDR_W] : m_adr_i[0 +: ADDR_W];
            s_dat_o = g ? m_dat_i[DATA_W +: DATA_W] : m_dat_i[0 +: DATA_W];
            s_sel_o = g ? m_sel_i[SEL_W +: SEL_W]   : m_sel_i[0 +: SEL_W];
        end

        accept  = s_stb_o & ~s_stall_i;
        // Responses with nothing outstanding are stale and must be swallowed.
        resp    = own & (out_q != 4'd0) & (s_ack_i | s_err_i | s_rty_i);
        wd_fire = (TIMEOUT != 0) & cyc_g & (out_q != 4'd0) & ~resp
                  & (timer_q == TMR_LAST);

        m_dat_o   = s_dat_i;
        m_ack_o   = 2'b00;
        m_err_o   = wd_err_q;
        m_rty_o   = 2'b00;
        m_stall_o = 2'b11;
        if (resp) begin
            m_ack_o[g] = s_ack_i;
            m_err_o[g] = m_err_o[g] | s_err_i;
            m_rty_o[g] = s_rty_i;
        end
        if (own) begin
            m_stall_o[g] = s_stall_i | full;
        end

        grant_o = {state_q == OWN1, state_q == OWN0};
    end

    // Ownership FSM, outstanding counter and watchdog timer.
    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            out_q    <= 4'd0;
            timer_q  <= '0;
            wd_err_q <= 2'b00;
        end else begin
            wd_err_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    out_q   <= 4'd0;
                    timer_q <= '0;
                    if (m_cyc_i == 2'b11) begin
                        state_q <= last_q ? OWN0 : OWN1;
                    end else if (m_cyc_i[0]) begin
                        state_q <= OWN0;
                    end else if (m_cyc_i[1]) begin
                        state_q <= OWN1;
                    end
                end
                default: begin
                    if (!cyc_g) begin
                        // Owner released (or aborted): drop everything in flight.
                        state_q <= IDLE;
                        last_q  <= g;
                        out_q   <= 4'd0;
                        timer_q <= '0;
                    end else if (wd_fire) begin
                        wd_err_q <= g ? 2'b10 : 2'b01;
                        out_q    <= 4'd0;
                        timer_q  <= '0;
                    end else begin
                        case ({accept, resp})
                            2'b10:   out_q <= out_q + 4'd1;
                            2'b01:   out_q <= out_q - 4'd1;
                            default: ;
                        endcase
                        if ((out_q != 4'd0) && !resp) begin
                            timer_q <= timer_q + 1'b1;
                        end else begin
                            timer_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
